// File: rtl/audio_pkg.sv
// Shared audio-path constants and types for the effect chain output stage.
package audio_pkg;
    localparam int SAMPLE_WIDTH = 24;
    localparam int SLOT_BITS    = 25;
    localparam int BCLK_HALF    = 20;
    localparam int FRAME_CYCLES = 2 * BCLK_HALF * 2 * SLOT_BITS;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
endpackage

// File: rtl/i2s_tx_timing.sv
// Bit-clock and frame counters for the I2S transmitter, plus next-state decodes
// so the top can register its line outputs in step with the counters.
module i2s_tx_timing
    import audio_pkg::*;
#(
    parameter int SLOT_BITS_P = SLOT_BITS,
    parameter int BCLK_HALF_P = BCLK_HALF,
    parameter int BW = $clog2(2 * BCLK_HALF_P),
    parameter int NW = $clog2(2 * SLOT_BITS_P),
    parameter int PW = $clog2(SLOT_BITS_P)
) (
    input  logic          system_clock,
    input  logic          rst,
    output logic          frame_start,
    output logic          frame_end,
    output logic          bclk_fall,
    output logic          bclk_high_next,
    output logic          lrclk_next,
    output logic [PW-1:0] pos_next
);
    localparam logic [BW-1:0] BCLK_LAST = BW'(2 * BCLK_HALF_P - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(2 * SLOT_BITS_P - 1);

    logic [BW-1:0] bclk_cnt_q, bclk_cnt_d;
    logic [NW-1:0] bit_cnt_q, bit_cnt_d;
    logic [NW-1:0] pos_full;

    always_comb begin
        bclk_fall   = (bclk_cnt_q == BCLK_LAST);
        frame_end   = bclk_fall && (bit_cnt_q == BIT_LAST);
        frame_start = (bclk_cnt_q == '0) && (bit_cnt_q == '0);

        bclk_cnt_d = bclk_fall ? '0 : bclk_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        if (bclk_fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end

        // Decodes of the values the counters take after this edge, so that
        // registered outputs line up exactly with the counter state.
        bclk_high_next = (bclk_cnt_d >= BW'(BCLK_HALF_P));
        lrclk_next     = (bit_cnt_d >= NW'(SLOT_BITS_P));
        pos_full       = lrclk_next ? (bit_cnt_d - NW'(SLOT_BITS_P)) : bit_cnt_d;
        pos_next       = PW'(pos_full);
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            bclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            bclk_cnt_q <= bclk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers one mono sample per frame and sends it MSB-first
// on both channels, flagging missed (underrun) and overwritten (overrun) samples.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int SLOT_BITS_P = SLOT_BITS,
    parameter int BCLK_HALF_P = BCLK_HALF
) (
    input  logic                           system_clock,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    input  logic                           clear_flags,
    output logic                           i2s_bclk,
    output logic                           i2s_lrclk,
    output logic                           i2s_sdata,
    output logic                           frame_start,
    output logic                           underrun,
    output logic                           overrun
);
    localparam int PW = $clog2(SLOT_BITS_P);

    logic          frame_end, bclk_fall, bclk_high_next, lrclk_next;
    logic [PW-1:0] pos_next;
    logic [PW-1:0] bit_idx;

    sample_t pending_q, pending_d;
    sample_t hold_q, hold_d;
    logic    pending_full_q, pending_full_d;
    logic    primed_q, primed_d;
    logic    bclk_q, bclk_d;
    logic    lrclk_q, lrclk_d;
    logic    sdata_q, sdata_d;
    logic    underrun_q, underrun_d;
    logic    overrun_q, overrun_d;
    logic    underrun_set, overrun_set;

    i2s_tx_timing #(
        .SLOT_BITS_P(SLOT_BITS_P),
        .BCLK_HALF_P(BCLK_HALF_P)
    ) u_timing (
        .system_clock  (system_clock),
        .rst           (rst),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .bclk_fall     (bclk_fall),
        .bclk_high_next(bclk_high_next),
        .lrclk_next    (lrclk_next),
        .pos_next      (pos_next)
    );

    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        hold_d         = hold_q;
        primed_d       = primed_q | sample_valid;
        underrun_set   = 1'b0;
        overrun_set    = 1'b0;

        if (frame_end) begin
            // A sample arriving exactly at frame end goes straight to the
            // hold register; nothing is left pending.
            if (sample_valid) begin
                hold_d         = sample_in;
                pending_full_d = 1'b0;
            end else if (pending_full_q) begin
                hold_d         = pending_q;
                pending_full_d = 1'b0;
            end else begin
                underrun_set = primed_q;
            end
        end else if (sample_valid) begin
            pending_d      = sample_in;
            pending_full_d = 1'b1;
            overrun_set    = pending_full_q;
        end

        underrun_d = underrun_set | (underrun_q & ~clear_flags);
        overrun_d  = overrun_set | (overrun_q & ~clear_flags);

        bclk_d  = bclk_high_next;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        bit_idx = PW'(SAMPLE_WIDTH) - pos_next;
        if (bclk_fall) begin
            lrclk_d = lrclk_next;
            sdata_d = (pos_next >= PW'(1)) && (pos_next <= PW'(SAMPLE_WIDTH)) ? hold_q[bit_idx] : 1'b0;
        end
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            primed_q       <= 1'b0;
            hold_q         <= '0;
            bclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            sdata_q        <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            primed_q       <= primed_d;
            hold_q         <= hold_d;
            bclk_q         <= bclk_d;
            lrclk_q        <= lrclk_d;
            sdata_q        <= sdata_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame timing, word serialization, and flag behaviour.
module tb_i2s_tx;
    import audio_pkg::*;

    logic        system_clock = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clear_flags = 1'b0;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    i2s_tx dut (
        .system_clock(system_clock),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clear_flags (clear_flags),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Advance to the next frame_start (sampled on the falling edge), bounded.
    task automatic wait_fs(input string ctx, output int cycles);
        cycles = 0;
        do begin
            @(negedge system_clock);
            cycles++;
        end while (!frame_start && cycles < 2100);
        check({ctx, "_fs"}, {31'b0, frame_start}, 32'd1);
    endtask

    // Called at the frame_start cycle; samples each bit at its BCLK rising point.
    task automatic capture(output logic [23:0] l, output logic [23:0] r,
                           output logic [1:0] pos0, output logic framing_err);
        l = '0; r = '0; pos0 = '0; framing_err = 1'b0;
        repeat (20) @(negedge system_clock);
        for (int k = 0; k < 50; k++) begin
            if (k == 0)       pos0[0] = i2s_sdata;
            else if (k < 25)  l[24-k] = i2s_sdata;
            else if (k == 25) pos0[1] = i2s_sdata;
            else              r[49-k] = i2s_sdata;
            if (i2s_lrclk !== (k >= 25)) framing_err = 1'b1;
            if (i2s_bclk !== 1'b1) framing_err = 1'b1;
            if (k < 49) repeat (40) @(negedge system_clock);
        end
    endtask

    task automatic send(input logic [23:0] s);
        sample_in = s;
        sample_valid = 1'b1;
        @(negedge system_clock);
        sample_valid = 1'b0;
        sample_in = '0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge system_clock);
        clear_flags = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [23:0] exp_word);
        logic [23:0] l, r;
        logic [1:0]  p0;
        logic        ferr;
        capture(l, r, p0, ferr);
        check({name, "_left"}, {8'b0, l}, {8'b0, exp_word});
        check({name, "_right"}, {8'b0, r}, {8'b0, exp_word});
        check({name, "_pos0"}, {30'b0, p0}, 32'd0);
        check({name, "_framing"}, {31'b0, ferr}, 32'd0);
    endtask

    typedef struct {
        logic [23:0] smp;
        int          off;
        logic [23:0] exp_word;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int wc;
        int fs_cnt, first_fs, last_fs, rise1, rise2;
        logic sd_seen, ur_seen, prev_bclk;

        tbl[0] = '{24'hABCDEF, 100,  24'hABCDEF};
        tbl[1] = '{24'h555555, 2,    24'h555555};
        tbl[2] = '{24'h800000, 1999, 24'h800000};
        tbl[3] = '{24'h0F0F0F, 1998, 24'h0F0F0F};
        tbl[4] = '{24'hFFFFFF, 1000, 24'hFFFFFF};

        // Reset state
        repeat (3) @(negedge system_clock);
        check("rst_bclk", {31'b0, i2s_bclk}, 32'd0);
        check("rst_lrclk", {31'b0, i2s_lrclk}, 32'd0);
        check("rst_sdata", {31'b0, i2s_sdata}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        rst = 1'b0;
        check("first_cycle_fs", {31'b0, frame_start}, 32'd1);

        // Startup: three idle frames, plus bit-clock and frame periods
        fs_cnt = 0; first_fs = -1; last_fs = -1; rise1 = -1; rise2 = -1;
        sd_seen = 1'b0; ur_seen = 1'b0; prev_bclk = i2s_bclk;
        for (int i = 1; i < 3 * FRAME_CYCLES; i++) begin
            @(negedge system_clock);
            if (i2s_bclk && !prev_bclk) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            prev_bclk = i2s_bclk;
            if (frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
                last_fs = i;
            end
            if (i2s_sdata) sd_seen = 1'b1;
            if (underrun) ur_seen = 1'b1;
        end
        check("bclk_first_rise", rise1, 32'd20);
        check("bclk_period", rise2 - rise1, 32'd40);
        check("fs_first", first_fs, 32'd2000);
        check("fs_second", last_fs, 32'd4000);
        check("fs_count", fs_cnt, 32'd2);
        check("startup_sdata", {31'b0, sd_seen}, 32'd0);
        check("startup_underrun", {31'b0, ur_seen}, 32'd0);

        // Table: one sample per frame at various offsets (1999 = frame_end bypass)
        for (int v = 0; v < 5; v++) begin
            wait_fs("tbl", wc);
            pulse_clear();
            check("tbl_cleared_ur", {31'b0, underrun}, 32'd0);
            repeat (tbl[v].off - 1) @(negedge system_clock);
            send(tbl[v].smp);
            if (!frame_start) wait_fs("tbl_next", wc);
            check("tbl_underrun", {31'b0, underrun}, 32'd0);
            check("tbl_overrun", {31'b0, overrun}, 32'd0);
            check_frame("tbl_word", tbl[v].exp_word);
        end

        // Underrun: one sample, then an empty frame
        wait_fs("ur", wc);
        pulse_clear();
        repeat (99) @(negedge system_clock);
        send(24'h000001);
        wait_fs("ur_b", wc);
        check("ur_before", {31'b0, underrun}, 32'd0);
        check_frame("ur_frame_b", 24'h000001);
        wait_fs("ur_c", wc);
        check("ur_set", {31'b0, underrun}, 32'd1);
        check_frame("ur_repeat", 24'h000001);
        pulse_clear();
        check("ur_cleared", {31'b0, underrun}, 32'd0);

        // Overrun: two samples in one frame, newer wins
        wait_fs("ov", wc);
        pulse_clear();
        check("ov_before", {31'b0, overrun}, 32'd0);
        repeat (99) @(negedge system_clock);
        send(24'h111111);
        repeat (99) @(negedge system_clock);
        send(24'h222222);
        check("ov_set", {31'b0, overrun}, 32'd1);
        wait_fs("ov_next", wc);
        check_frame("ov_word", 24'h222222);

        // Reset mid-frame while transmitting 0x7FFFFF with overrun set
        wait_fs("mr", wc);
        pulse_clear();
        repeat (99) @(negedge system_clock);
        send(24'h7FFFFF);
        repeat (99) @(negedge system_clock);
        send(24'h7FFFFF);
        wait_fs("mr_tx", wc);
        repeat (1210) @(negedge system_clock);
        check("mr_pre_lrclk", {31'b0, i2s_lrclk}, 32'd1);
        check("mr_pre_sdata", {31'b0, i2s_sdata}, 32'd1);
        check("mr_pre_overrun", {31'b0, overrun}, 32'd1);
        rst = 1'b1;
        @(negedge system_clock);
        rst = 1'b0;
        check("mr_bclk", {31'b0, i2s_bclk}, 32'd0);
        check("mr_lrclk", {31'b0, i2s_lrclk}, 32'd0);
        check("mr_sdata", {31'b0, i2s_sdata}, 32'd0);
        check("mr_underrun", {31'b0, underrun}, 32'd0);
        check("mr_overrun", {31'b0, overrun}, 32'd0);
        check("mr_fs_release", {31'b0, frame_start}, 32'd1);
        check_frame("mr_word", 24'h000000);
        wait_fs("mr_after", wc);
        check("mr_period_tail", wc, 32'd20);
        check("mr_not_primed", {31'b0, underrun}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
